// File: rtl/state_deserializer_if.sv
// Byte-stream transport into the state deserializer: one byte moves on each cycle
// where valid and ready are both high.
interface state_deserializer_if;
  logic [7:0] in_byte;
  logic       in_byte_valid;
  logic       in_byte_ready;

  modport master (output in_byte, output in_byte_valid, input in_byte_ready);
  modport slave  (input in_byte, input in_byte_valid, output in_byte_ready);
endinterface

// File: rtl/state_deserializer.sv
// Canonical state-stream decoder: rebuilds module tables, mu-ledger, pc, halted,
// result and program hash from a byte stream, and rejects non-canonical streams.
module state_deserializer #(
  parameter int MAX_MODULES         = 16,
  parameter int MAX_VARS_PER_MODULE = 32,
  localparam int MI_W = $clog2(MAX_MODULES),
  localparam int VI_W = $clog2(MAX_VARS_PER_MODULE)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                error_o,
  output logic [2:0]          err_code_o,
  output logic                state_valid_o,
  state_deserializer_if.slave in_if,
  output logic [31:0]         num_modules_o,
  input  logic [MI_W-1:0]     rd_mod_idx_i,
  input  logic [VI_W-1:0]     rd_var_idx_i,
  output logic [31:0]         rd_module_id_o,
  output logic [31:0]         rd_var_count_o,
  output logic [31:0]         rd_variable_o,
  output logic signed [63:0]  mu_ledger_o,
  output logic [31:0]         pc_o,
  output logic                halted_o,
  output logic [31:0]         result_o,
  output logic [255:0]        program_hash_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_NUM_MOD, S_MOD_ID, S_VAR_CNT, S_VARS, S_MU, S_PC,
    S_HALTED, S_RESULT, S_HASH, S_DONE, S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic [4:0]          byte_cnt_q;
  logic [MI_W-1:0]     mod_idx_q;
  logic [VI_W-1:0]     var_idx_q;
  logic [31:0]         acc_q, acc_d;
  logic [31:0]         num_mod_q;
  logic [31:0]         mod_id_q  [MAX_MODULES];
  logic [31:0]         var_cnt_q [MAX_MODULES];
  logic [31:0]         vars_q    [MAX_MODULES][MAX_VARS_PER_MODULE];
  logic signed [63:0]  mu_q;
  logic [31:0]         pc_q, result_q;
  logic                halted_q, state_valid_q;
  logic [255:0]        hash_q;
  logic [2:0]          err_code_q, err_new;

  logic                xfer, field_end, last_mod, vars_done;
  logic [4:0]          last_idx;
  logic [31:0]         prev_id;

  assign xfer      = in_if.in_byte_valid && in_if.in_byte_ready;
  assign acc_d     = {in_if.in_byte, acc_q[31:8]};
  assign field_end = xfer && (byte_cnt_q == last_idx);
  assign last_mod  = (32'(mod_idx_q) + 32'd1) == num_mod_q;
  assign vars_done = (32'(var_idx_q) + 32'd1) == var_cnt_q[mod_idx_q];
  assign prev_id   = mod_id_q[mod_idx_q - MI_W'(1)];

  always_comb begin
    case (state_q)
      S_MU:     last_idx = 5'd7;
      S_HALTED: last_idx = 5'd0;
      S_HASH:   last_idx = 5'd31;
      default:  last_idx = 5'd3;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; check failures are judged with the final byte folded in
  always_comb begin
    state_d = state_q;
    err_new = 3'd0;
    case (state_q)
      S_IDLE:    if (start_i) state_d = S_NUM_MOD;
      S_NUM_MOD: if (field_end) begin
        if (acc_d > 32'(MAX_MODULES)) begin state_d = S_ERR; err_new = 3'd1; end
        else if (acc_d == '0)         state_d = S_MU;
        else                          state_d = S_MOD_ID;
      end
      S_MOD_ID:  if (field_end) begin
        if (mod_idx_q != '0 && acc_d <= prev_id) begin state_d = S_ERR; err_new = 3'd3; end
        else                                      state_d = S_VAR_CNT;
      end
      S_VAR_CNT: if (field_end) begin
        if (acc_d > 32'(MAX_VARS_PER_MODULE)) begin state_d = S_ERR; err_new = 3'd2; end
        else if (acc_d == '0) state_d = last_mod ? S_MU : S_MOD_ID;
        else                  state_d = S_VARS;
      end
      S_VARS:    if (field_end && vars_done) state_d = last_mod ? S_MU : S_MOD_ID;
      S_MU:      if (field_end) state_d = S_PC;
      S_PC:      if (field_end) state_d = S_HALTED;
      S_HALTED:  if (field_end) begin
        if (in_if.in_byte > 8'd1) begin state_d = S_ERR; err_new = 3'd4; end
        else                            state_d = S_RESULT;
      end
      S_RESULT:  if (field_end) state_d = S_HASH;
      S_HASH:    if (field_end) state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_o             = (state_q != S_IDLE);
    done_o             = (state_q == S_DONE);
    error_o            = (state_q == S_ERR);
    in_if.in_byte_ready = state_q inside {S_NUM_MOD, S_MOD_ID, S_VAR_CNT, S_VARS,
                                          S_MU, S_PC, S_HALTED, S_RESULT, S_HASH};
  end

  // Counters, status and decoded fields; fields update live as bytes arrive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q    <= '0;
      mod_idx_q     <= '0;
      var_idx_q     <= '0;
      acc_q         <= '0;
      num_mod_q     <= '0;
      mu_q          <= '0;
      pc_q          <= '0;
      halted_q      <= 1'b0;
      result_q      <= '0;
      hash_q        <= '0;
      state_valid_q <= 1'b0;
      err_code_q    <= '0;
      for (int m = 0; m < MAX_MODULES; m++) begin
        mod_id_q[m]  <= '0;
        var_cnt_q[m] <= '0;
        for (int v = 0; v < MAX_VARS_PER_MODULE; v++) vars_q[m][v] <= '0;
      end
    end else begin
      if (state_q == S_IDLE && start_i) begin
        byte_cnt_q    <= '0;
        mod_idx_q     <= '0;
        var_idx_q     <= '0;
        state_valid_q <= 1'b0;
        err_code_q    <= '0;
      end
      if (state_q == S_DONE) state_valid_q <= 1'b1;
      if (err_new != 3'd0)   err_code_q    <= err_new;
      if (xfer) begin
        acc_q      <= acc_d;
        byte_cnt_q <= field_end ? 5'd0 : byte_cnt_q + 5'd1;
        case (state_q)
          S_NUM_MOD: num_mod_q            <= acc_d;
          S_MOD_ID:  mod_id_q[mod_idx_q]  <= acc_d;
          S_VAR_CNT: var_cnt_q[mod_idx_q] <= acc_d;
          S_VARS:    vars_q[mod_idx_q][var_idx_q] <= acc_d;
          S_MU:      mu_q     <= {mu_q[55:0], in_if.in_byte};
          S_PC:      pc_q     <= acc_d;
          S_HALTED:  halted_q <= in_if.in_byte[0];
          S_RESULT:  result_q <= acc_d;
          S_HASH:    hash_q   <= {hash_q[247:0], in_if.in_byte};
          default:   ;
        endcase
      end
      if (field_end && state_q == S_VAR_CNT) var_idx_q <= '0;
      if (field_end && state_q == S_VARS)    var_idx_q <= var_idx_q + VI_W'(1);
      if (field_end && state_d == S_MOD_ID && (state_q == S_VAR_CNT || state_q == S_VARS))
        mod_idx_q <= mod_idx_q + MI_W'(1);
    end
  end

  assign err_code_o     = err_code_q;
  assign state_valid_o  = state_valid_q;
  assign num_modules_o  = num_mod_q;
  assign rd_module_id_o = mod_id_q[rd_mod_idx_i];
  assign rd_var_count_o = var_cnt_q[rd_mod_idx_i];
  assign rd_variable_o  = vars_q[rd_mod_idx_i][rd_var_idx_i];
  assign mu_ledger_o    = mu_q;
  assign pc_o           = pc_q;
  assign halted_o       = halted_q;
  assign result_o       = result_q;
  assign program_hash_o = hash_q;

endmodule
